// File: rtl/maple_tx_if.sv
// Byte stream into the Maple transmitter: payload, frame-last flag and valid/ready handshake.
interface maple_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, input  tx_last, output tx_ready);
endinterface

// File: rtl/maple_tx.sv
// Maple bus transmitter: frames streamed bytes onto SDCKA/SDCKB with start/end patterns
// and an optional trailing XOR checksum byte.
module maple_tx #(
  parameter int unsigned PHASE_TICKS = 20,
  parameter bit          APPEND_CRC  = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  maple_tx_if.slave tx,
  output logic      pin1_out,
  output logic      pin5_out,
  output logic      pins_oe,
  output logic      busy,
  output logic      done,
  output logic      underrun
);
  localparam int unsigned TW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam int unsigned PW = 4;
  localparam int unsigned BW = 3;
  localparam logic [PW-1:0] START_LAST = PW'(10);
  localparam logic [PW-1:0] END_LAST   = PW'(5);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END, S_RELEASE} state_t;

  state_t        state_q, state_n;
  logic [TW-1:0] tick_q, tick_n;
  logic [PW-1:0] phase_q, phase_n;
  logic [BW-1:0] bit_q, bit_n;
  logic          strobe_q, strobe_n;
  logic [7:0]    shift_q, shift_n;
  logic          last_q, last_n;
  logic [7:0]    csum_q, csum_n;
  logic          uflag_q, uflag_n;
  logic          hold_full_q, hold_full_n;
  logic [7:0]    hold_data_q, hold_data_n;
  logic          hold_last_q, hold_last_n;
  logic          pin1_n, pin5_n, oe_n, done_n, underrun_n;
  logic          line_clk, line_dat;
  logic          phase_end;

  assign phase_end   = (tick_q == TW'(PHASE_TICKS - 1));
  assign tx.tx_ready = ~hold_full_q;

  // Next-state, holding register and the pin values for the phase being entered
  always_comb begin
    state_n     = state_q;
    phase_n     = phase_q;
    bit_n       = bit_q;
    strobe_n    = strobe_q;
    shift_n     = shift_q;
    last_n      = last_q;
    csum_n      = csum_q;
    uflag_n     = uflag_q;
    hold_full_n = hold_full_q;
    hold_data_n = hold_data_q;
    hold_last_n = hold_last_q;
    done_n      = 1'b0;
    underrun_n  = 1'b0;
    pin1_n      = 1'b1;
    pin5_n      = 1'b1;
    oe_n        = 1'b1;
    line_clk    = 1'b1;
    line_dat    = 1'b1;
    tick_n      = (state_q == S_IDLE || phase_end) ? '0 : tick_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          state_n     = S_START;
          phase_n     = '0;
          shift_n     = hold_data_q;
          last_n      = hold_last_q;
          hold_full_n = 1'b0;
          csum_n      = '0;
          uflag_n     = 1'b0;
        end
      end
      S_START: begin
        if (phase_end) begin
          if (phase_q == START_LAST) begin
            state_n  = S_DATA;
            bit_n    = BW'(7);
            strobe_n = 1'b0;
          end else begin
            phase_n = phase_q + PW'(1);
          end
        end
      end
      S_DATA, S_CRC: begin
        if (phase_end) begin
          if (!strobe_q) begin
            strobe_n = 1'b1;
          end else begin
            strobe_n = 1'b0;
            bit_n    = bit_q - BW'(1);
            if (bit_q == '0) begin
              bit_n = BW'(7);
              if (state_q == S_CRC) begin
                state_n = S_END;
                phase_n = '0;
              end else begin
                csum_n = csum_q ^ shift_q;
                if (last_q) begin
                  if (APPEND_CRC) begin
                    state_n = S_CRC;
                    shift_n = csum_q ^ shift_q;
                  end else begin
                    state_n = S_END;
                    phase_n = '0;
                  end
                end else if (hold_full_q) begin
                  shift_n     = hold_data_q;
                  last_n      = hold_last_q;
                  hold_full_n = 1'b0;
                end else begin
                  // Starved mid-frame: close the frame without a checksum
                  underrun_n = 1'b1;
                  uflag_n    = 1'b1;
                  state_n    = S_END;
                  phase_n    = '0;
                end
              end
            end
          end
        end
      end
      S_END: begin
        if (phase_end) begin
          if (phase_q == END_LAST) begin
            state_n = S_RELEASE;
          end else begin
            phase_n = phase_q + PW'(1);
          end
        end
      end
      S_RELEASE: begin
        if (phase_end) begin
          state_n = S_IDLE;
          done_n  = ~uflag_q;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (tx.tx_valid && !hold_full_q) begin
      hold_full_n = 1'b1;
      hold_data_n = tx.tx_data;
      hold_last_n = tx.tx_last;
    end

    // Line levels are a pure function of the upcoming state so they move only on phase boundaries
    case (state_n)
      S_IDLE: oe_n = 1'b0;
      S_START: begin
        if (phase_n >= PW'(1) && phase_n <= PW'(9)) pin1_n = 1'b0;
        if (phase_n >= PW'(2) && phase_n <= PW'(9)) pin5_n = phase_n[0];
      end
      S_DATA, S_CRC: begin
        line_clk = ~strobe_n;
        line_dat = shift_n[bit_n];
        if (bit_n[0]) begin
          pin1_n = line_clk;
          pin5_n = line_dat;
        end else begin
          pin5_n = line_clk;
          pin1_n = line_dat;
        end
      end
      S_END: begin
        if (phase_n <= PW'(4)) pin5_n = 1'b0;
        if (phase_n >= PW'(1) && phase_n <= PW'(4)) pin1_n = ~phase_n[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      phase_q     <= '0;
      bit_q       <= BW'(7);
      strobe_q    <= 1'b0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      csum_q      <= '0;
      uflag_q     <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      pin1_out    <= 1'b1;
      pin5_out    <= 1'b1;
      pins_oe     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_n;
      tick_q      <= tick_n;
      phase_q     <= phase_n;
      bit_q       <= bit_n;
      strobe_q    <= strobe_n;
      shift_q     <= shift_n;
      last_q      <= last_n;
      csum_q      <= csum_n;
      uflag_q     <= uflag_n;
      hold_full_q <= hold_full_n;
      hold_data_q <= hold_data_n;
      hold_last_q <= hold_last_n;
      pin1_out    <= pin1_n;
      pin5_out    <= pin5_n;
      pins_oe     <= oe_n;
      busy        <= (state_n != S_IDLE);
      done        <= done_n;
      underrun    <= underrun_n;
    end
  end
endmodule

// File: tb/tb_maple_tx.sv
// Directed bench for maple_tx: captures the driven lines while busy and decodes them
// with an independent Maple sniffer model.
module tb_maple_tx;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic pin1_a, pin5_a, oe_a, busy_a, done_a, ur_a;
  logic pin1_b, pin5_b, oe_b, busy_b, done_b, ur_b;

  int checks = 0;
  int failures = 0;
  int done_cnt_a = 0, ur_cnt_a = 0, done_cnt_b = 0, ur_cnt_b = 0;
  logic [2:0] trace_a[$];
  logic [2:0] trace_b[$];
  logic [7:0] dec [8];

  maple_tx_if ifa ();
  maple_tx_if ifb ();

  maple_tx #(.PHASE_TICKS(2), .APPEND_CRC(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .tx(ifa),
    .pin1_out(pin1_a), .pin5_out(pin5_a), .pins_oe(oe_a),
    .busy(busy_a), .done(done_a), .underrun(ur_a)
  );

  maple_tx #(.PHASE_TICKS(1), .APPEND_CRC(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .tx(ifb),
    .pin1_out(pin1_b), .pin5_out(pin5_b), .pins_oe(oe_b),
    .busy(busy_b), .done(done_b), .underrun(ur_b)
  );

  always #5 clk = ~clk;

  // Line trace {pin1,pin5,oe} per busy cycle plus pulse counters
  always @(negedge clk) begin
    if (busy_a) trace_a.push_back({pin1_a, pin5_a, oe_a});
    if (busy_b) trace_b.push_back({pin1_b, pin5_b, oe_b});
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (ur_a)   ur_cnt_a   <= ur_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (ur_b)   ur_cnt_b   <= ur_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input bit sel, input logic [7:0] d, input bit last, input bit keep);
    int n = 0;
    if (sel) begin ifb.tx_data = d; ifb.tx_last = last; ifb.tx_valid = 1'b1; end
    else     begin ifa.tx_data = d; ifa.tx_last = last; ifa.tx_valid = 1'b1; end
    while (((sel ? ifb.tx_ready : ifa.tx_ready) !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", sel ? ifb.tx_ready : ifa.tx_ready, 1);
    @(negedge clk);
    if (!keep) begin
      if (sel) ifb.tx_valid = 1'b0; else ifa.tx_valid = 1'b0;
    end
  endtask

  task automatic wait_busy(input bit sel, input bit level, input string tag);
    int n = 0;
    while (((sel ? busy_b : busy_a) !== level) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sel ? busy_b : busy_a, level);
  endtask

  // Sniffer model: checks start/end/release patterns and strobe discipline, recovers bytes
  task automatic decode(input logic [2:0] tr[$], input int base, input int pt,
                        output int nb, output int errs);
    logic [10:0] st1, st5;
    logic [5:0]  en1, en5;
    logic [2:0]  s, u;
    logic [7:0]  by;
    int len, np, p;
    st1 = 11'b10000000001;
    st5 = 11'b11010101011;
    en1 = 6'b101011;
    en5 = 6'b000001;
    errs = 0;
    len = tr.size() - base;
    np = len / pt;
    if (np * pt != len || np < 18) errs++;
    nb = (np >= 18) ? (np - 18) / 16 : 0;
    if (nb > 8) nb = 8;
    for (int k = 0; k < np; k++) begin
      s = tr[base + k*pt];
      if (s[0] !== 1'b1) errs++;
      for (int j = 1; j < pt; j++) if (tr[base + k*pt + j] !== s) errs++;
    end
    for (int k = 0; k < 11 && k < np; k++) begin
      s = tr[base + k*pt];
      if (s[2] !== st1[10-k] || s[1] !== st5[10-k]) errs++;
    end
    for (int b = 0; b < nb; b++) begin
      by = '0;
      for (int i = 0; i < 8; i++) begin
        p = 11 + 16*b + 2*i;
        s = tr[base + p*pt];
        u = tr[base + (p+1)*pt];
        if (i % 2 == 0) begin
          if (s[2] !== 1'b1 || u[2] !== 1'b0 || s[1] !== u[1]) errs++;
          by = {by[6:0], s[1]};
        end else begin
          if (s[1] !== 1'b1 || u[1] !== 1'b0 || s[2] !== u[2]) errs++;
          by = {by[6:0], s[2]};
        end
      end
      dec[b] = by;
    end
    for (int k = 0; k < 6; k++) begin
      p = 11 + 16*nb + k;
      if (p < np) begin
        s = tr[base + p*pt];
        if (s[2] !== en1[5-k] || s[1] !== en5[5-k]) errs++;
      end
    end
    if (np >= 18) begin
      s = tr[base + (np-1)*pt];
      if (s !== 3'b111) errs++;
    end
  endtask

  initial begin
    int t0, t1, d0, u0, nb, errs;
    ifa.tx_valid = 1'b0; ifa.tx_data = '0; ifa.tx_last = 1'b0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0; ifb.tx_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ifa.tx_ready, 1);
    chk("rst_pins", {pin1_a, pin5_a, oe_a}, 3'b110);
    chk("rst_status", {busy_a, done_a, ur_a}, 3'b000);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_pins", {pin1_a, pin5_a, oe_a, busy_a}, 4'b1100);

    // 1: single byte, checksum equals the byte
    t0 = trace_a.size(); d0 = done_cnt_a; u0 = ur_cnt_a;
    send_byte(0, 8'hA5, 1'b1, 1'b0);
    wait_busy(0, 1'b1, "t1_busy_rise");
    wait_busy(0, 1'b0, "t1_busy_fall");
    chk("t1_done_at_idle", done_a, 1);
    chk("t1_len", trace_a.size() - t0, 100);
    decode(trace_a, t0, 2, nb, errs);
    chk("t1_format", errs, 0);
    chk("t1_nbytes", nb, 2);
    chk("t1_byte0", dec[0], 8'hA5);
    chk("t1_crc", dec[1], 8'hA5);
    @(negedge clk);
    chk("t1_done_pulse", done_a, 0);
    chk("t1_done_count", done_cnt_a - d0, 1);
    chk("t1_no_underrun", ur_cnt_a - u0, 0);

    // 2: four bytes with valid held high
    t0 = trace_a.size(); d0 = done_cnt_a; u0 = ur_cnt_a;
    send_byte(0, 8'h01, 1'b0, 1'b1);
    send_byte(0, 8'h02, 1'b0, 1'b1);
    send_byte(0, 8'h04, 1'b0, 1'b1);
    send_byte(0, 8'h08, 1'b1, 1'b0);
    wait_busy(0, 1'b1, "t2_busy_rise");
    wait_busy(0, 1'b0, "t2_busy_fall");
    chk("t2_len", trace_a.size() - t0, 196);
    decode(trace_a, t0, 2, nb, errs);
    chk("t2_format", errs, 0);
    chk("t2_nbytes", nb, 5);
    chk("t2_bytes", {dec[0], dec[1], dec[2], dec[3]}, 32'h01020408);
    chk("t2_crc", dec[4], 8'h0F);
    @(negedge clk);
    chk("t2_no_underrun", ur_cnt_a - u0, 0);
    chk("t2_done_count", done_cnt_a - d0, 1);

    // 3: byte without last, stream then starves
    t0 = trace_a.size(); d0 = done_cnt_a; u0 = ur_cnt_a;
    send_byte(0, 8'h55, 1'b0, 1'b0);
    wait_busy(0, 1'b1, "t3_busy_rise");
    wait_busy(0, 1'b0, "t3_busy_fall");
    chk("t3_no_done", done_a, 0);
    chk("t3_oe_off", oe_a, 0);
    chk("t3_len", trace_a.size() - t0, 68);
    decode(trace_a, t0, 2, nb, errs);
    chk("t3_format", errs, 0);
    chk("t3_nbytes", nb, 1);
    chk("t3_byte0", dec[0], 8'h55);
    repeat (3) @(negedge clk);
    chk("t3_underrun_count", ur_cnt_a - u0, 1);
    chk("t3_done_count", done_cnt_a - d0, 0);

    // 4: reset during bit 3, then a clean frame
    d0 = done_cnt_a;
    send_byte(0, 8'h3C, 1'b1, 1'b0);
    wait_busy(0, 1'b1, "t4_busy_rise");
    repeat (39) @(negedge clk);
    chk("t4_mid_frame", busy_a, 1);
    rst_a = 1'b1;
    #1;
    chk("t4_rst_pins", {pin1_a, pin5_a, oe_a}, 3'b110);
    chk("t4_rst_ready", ifa.tx_ready, 1);
    chk("t4_rst_busy", busy_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("t4_abort_no_done", done_cnt_a - d0, 0);
    t0 = trace_a.size();
    send_byte(0, 8'h81, 1'b1, 1'b0);
    wait_busy(0, 1'b1, "t4_busy_rise2");
    wait_busy(0, 1'b0, "t4_busy_fall2");
    chk("t4_len", trace_a.size() - t0, 100);
    decode(trace_a, t0, 2, nb, errs);
    chk("t4_format", errs, 0);
    chk("t4_frame", {dec[0], dec[1]}, 16'h8181);
    @(negedge clk);

    // 5: back-to-back frames, second byte offered during END
    t0 = trace_a.size(); d0 = done_cnt_a;
    send_byte(0, 8'h11, 1'b1, 1'b0);
    wait_busy(0, 1'b1, "t5_busy_rise");
    repeat (88) @(negedge clk);
    send_byte(0, 8'h22, 1'b1, 1'b0);
    chk("t5_accept_in_frame", busy_a, 1);
    chk("t5_held", ifa.tx_ready, 0);
    wait_busy(0, 1'b0, "t5_busy_fall");
    chk("t5_done1", done_a, 1);
    chk("t5_len1", trace_a.size() - t0, 100);
    decode(trace_a, t0, 2, nb, errs);
    chk("t5_format1", errs, 0);
    chk("t5_frame1", {dec[0], dec[1]}, 16'h1111);
    t1 = trace_a.size();
    @(negedge clk);
    chk("t5_restart", {busy_a, done_a}, 2'b10);
    wait_busy(0, 1'b0, "t5_busy_fall2");
    chk("t5_len2", trace_a.size() - t1, 100);
    decode(trace_a, t1, 2, nb, errs);
    chk("t5_format2", errs, 0);
    chk("t5_frame2", {dec[0], dec[1]}, 16'h2222);
    @(negedge clk);
    chk("t5_done_count", done_cnt_a - d0, 2);

    // 6: no checksum, one tick per phase
    t0 = trace_b.size(); d0 = done_cnt_b;
    send_byte(1, 8'hFF, 1'b1, 1'b0);
    wait_busy(1, 1'b1, "t6_busy_rise");
    wait_busy(1, 1'b0, "t6_busy_fall");
    chk("t6_len", trace_b.size() - t0, 34);
    decode(trace_b, t0, 1, nb, errs);
    chk("t6_format", errs, 0);
    chk("t6_nbytes", nb, 1);
    chk("t6_byte0", dec[0], 8'hFF);
    @(negedge clk);
    chk("t6_done_count", done_cnt_b - d0, 1);
    chk("t6_no_underrun", ur_cnt_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
